// File: rtl/kronos_spm_responder_pkg.sv
// Shared Kronos types used by the data-side scratchpad responder.
// Holds the latched load/store request bundle and wait-state limit.
package kronos_types;

   parameter int unsigned SPM_WAIT_MAX = 15;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr_en;
      logic [3:0]  mask;
      logic [31:0] wr_data;
   } dmem_req_t;

endpackage

// File: rtl/kronos_spm_ram.sv
// Single-port DEPTH x 32 scratchpad array.
// Byte-lane write enables and a registered read port.
module kronos_spm_ram #(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          wr_en,
   input  logic [3:0]    mask,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
               if (mask[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end else begin
            rd_data <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/kronos_spm_responder.sv
// Scratchpad responder for the Kronos data bus: req/ack slave with
// programmable wait states and out-of-range access faults.
module kronos_spm_responder
   import kronos_types::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic        data_req,
   input  logic        data_wr_en,
   input  logic [3:0]  data_mask,
   input  logic [31:0] data_wr_data,
   output logic [31:0] data_rd_data,
   output logic        data_ack,
   output logic        data_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(SPM_WAIT_MAX + 1);
   localparam logic [32:0] LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI = LO + 33'(4 * DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   dmem_req_t     req_q;
   dmem_req_t     cur;
   logic          in_range;
   logic          go;
   logic          ram_en;
   logic [31:0]   ram_rd;

   // With zero wait states the array is touched on the accept edge,
   // so the live bus is used while idle and the latched copy after.
   always_comb begin
      cur = req_q;
      if (state == IDLE) begin
         cur.addr    = data_addr;
         cur.wr_en   = data_wr_en;
         cur.mask    = data_mask;
         cur.wr_data = data_wr_data;
      end
   end

   assign in_range = ({1'b0, cur.addr} >= LO) && ({1'b0, cur.addr} < HI);

   assign go = ((state == IDLE) && data_req && (WAIT_STATES == 0))
            || ((state == WAIT) && (cnt == CW'(1)));

   assign ram_en = go && in_range && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         req_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (data_req) begin
                  req_q <= cur;
                  cnt   <= CW'(WAIT_STATES);
                  state <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   kronos_spm_ram #(
      .DEPTH(DEPTH)
   ) u_ram (
      .clk    (clk),
      .en     (ram_en),
      .wr_en  (cur.wr_en),
      .mask   (cur.mask),
      .addr   (cur.addr[AW+1:2]),
      .wr_data(cur.wr_data),
      .rd_data(ram_rd)
   );

   assign data_ack     = (state == RESP);
   assign data_err     = data_ack && !in_range;
   assign data_rd_data = (data_ack && in_range && !req_q.wr_en) ? ram_rd : '0;

endmodule

// File: tb/tb_kronos_spm_responder.sv
// Bench for kronos_spm_responder: four instances (0/1/15/3 wait states,
// DEPTH=256) driven from a vector table, with scoreboarded responses.
module tb_kronos_spm_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  mask;
   logic [31:0] wd;
   logic [3:0]  req;
   logic [3:0]  ack;
   logic [3:0]  err;
   logic [31:0] rd [4];

   int ws [4] = '{0, 1, 15, 3};
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          d;
      logic        w;
      logic [31:0] a;
      logic [3:0]  m;
      logic [31:0] wdat;
      logic        e;
      logic [31:0] r;
   } vec_t;

   typedef struct {
      logic        e;
      logic [31:0] r;
      int          lat;
   } exp_t;

   vec_t vt [$];
   exp_t sb [$];

   always #5 clk = ~clk;

   kronos_spm_responder #(.DEPTH(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .data_addr(addr), .data_req(req[0]), .data_wr_en(we),
      .data_mask(mask), .data_wr_data(wd), .data_rd_data(rd[0]), .data_ack(ack[0]),
      .data_err(err[0]));

   kronos_spm_responder #(.DEPTH(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst(rst), .data_addr(addr), .data_req(req[1]), .data_wr_en(we),
      .data_mask(mask), .data_wr_data(wd), .data_rd_data(rd[1]), .data_ack(ack[1]),
      .data_err(err[1]));

   kronos_spm_responder #(.DEPTH(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(15)) u_ws15 (
      .clk(clk), .rst(rst), .data_addr(addr), .data_req(req[2]), .data_wr_en(we),
      .data_mask(mask), .data_wr_data(wd), .data_rd_data(rd[2]), .data_ack(ack[2]),
      .data_err(err[2]));

   kronos_spm_responder #(.DEPTH(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst), .data_addr(addr), .data_req(req[3]), .data_wr_en(we),
      .data_mask(mask), .data_wr_data(wd), .data_rd_data(rd[3]), .data_ack(ack[3]),
      .data_err(err[3]));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp_v);
      end
   endtask

   task automatic txn(int d, logic w, logic [31:0] a, logic [3:0] m,
                      logic [31:0] wdat, logic e, logic [31:0] r);
      exp_t x;
      int   k;
      bit   quiet;
      @(negedge clk);
      addr = a; we = w; mask = m; wd = wdat; req[d] = 1'b1;
      sb.push_back('{e, r, 1 + ws[d]});
      k = 0;
      quiet = 1'b1;
      do begin
         @(negedge clk);
         k++;
         if (!ack[d] && (rd[d] !== 32'h0 || err[d] !== 1'b0)) quiet = 1'b0;
      end while (!ack[d] && k < 40);
      req[d] = 1'b0;
      x = sb.pop_front();
      chk($sformatf("ack_seen d%0d a%h", d, a), 32'(ack[d]), 32'h1);
      chk($sformatf("latency d%0d a%h", d, a), k, x.lat);
      chk($sformatf("err d%0d a%h", d, a), 32'(err[d]), 32'(x.e));
      chk($sformatf("rd_data d%0d a%h", d, a), rd[d], x.r);
      chk($sformatf("idle_quiet d%0d a%h", d, a), 32'(quiet), 32'h1);
      @(negedge clk);
      chk($sformatf("ack_single d%0d", d), {ack[d], err[d]}, 32'h0);
      chk($sformatf("rd_zero_after d%0d", d), rd[d], 32'h0);
   endtask

   task automatic b2b(int d, logic [31:0] a, logic [31:0] r);
      int   first;
      int   per;
      logic expk;
      exp_t x;
      first = 1 + ws[d];
      per   = 2 + ws[d];
      @(negedge clk);
      addr = a; we = 1'b0; mask = 4'h0; wd = 32'h0; req[d] = 1'b1;
      for (int k = 1; k <= 3 * per; k++) begin
         @(negedge clk);
         expk = (k >= first) && ((k - first) % per == 0);
         if (expk) sb.push_back('{1'b0, r, k});
         chk($sformatf("b2b_ack d%0d k%0d", d, k), 32'(ack[d]), 32'(expk));
         if (ack[d] && sb.size() > 0) begin
            x = sb.pop_front();
            chk($sformatf("b2b_rd d%0d k%0d", d, k), rd[d], x.r);
         end
      end
      req[d] = 1'b0;
      chk($sformatf("b2b_sb_empty d%0d", d), sb.size(), 32'h0);
      sb.delete();
      @(negedge clk);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; req = 4'h0; addr = '0; we = 1'b0; mask = '0; wd = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("reset_out d%0d", d), {rd[d][30:0], ack[d]}, 32'h0);
         chk($sformatf("reset_err d%0d", d), 32'(err[d]), 32'h0);
      end
      rst = 1'b0;

      vt.push_back('{1, 1'b1, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0});
      vt.push_back('{1, 1'b1, 32'h0001_0004, 4'h1, 32'h0000_00AA, 1'b0, 32'h0});
      vt.push_back('{1, 1'b0, 32'h0001_0004, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEAA});
      vt.push_back('{1, 1'b1, 32'h0001_0004, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0});
      vt.push_back('{1, 1'b0, 32'h0001_0004, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEAA});
      vt.push_back('{1, 1'b1, 32'h0001_0000, 4'hF, 32'h0,         1'b0, 32'h0});
      vt.push_back('{1, 1'b1, 32'h0001_0000, 4'h6, 32'hA5A5_A5A5, 1'b0, 32'h0});
      vt.push_back('{1, 1'b0, 32'h0001_0000, 4'h0, 32'h0,         1'b0, 32'h00A5_A500});
      vt.push_back('{1, 1'b1, 32'h0001_03FC, 4'hF, 32'h1122_3344, 1'b0, 32'h0});
      vt.push_back('{1, 1'b0, 32'h0001_03FC, 4'h0, 32'h0,         1'b0, 32'h1122_3344});
      vt.push_back('{1, 1'b0, 32'h0001_0400, 4'h0, 32'h0,         1'b1, 32'h0});
      vt.push_back('{1, 1'b1, 32'h0000_FFFC, 4'hF, 32'h5555_5555, 1'b1, 32'h0});
      vt.push_back('{1, 1'b0, 32'h0001_03FC, 4'h0, 32'h0,         1'b0, 32'h1122_3344});
      vt.push_back('{1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         1'b1, 32'h0});
      vt.push_back('{0, 1'b1, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0});
      vt.push_back('{0, 1'b0, 32'h0001_0004, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF});
      vt.push_back('{0, 1'b0, 32'h0001_0400, 4'h0, 32'h0,         1'b1, 32'h0});
      vt.push_back('{2, 1'b1, 32'h0001_0008, 4'hF, 32'h0102_0304, 1'b0, 32'h0});
      vt.push_back('{2, 1'b0, 32'h0001_0008, 4'h0, 32'h0,         1'b0, 32'h0102_0304});
      vt.push_back('{3, 1'b1, 32'h0001_0010, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0});
      vt.push_back('{3, 1'b0, 32'h0001_0010, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D});

      foreach (vt[i])
         txn(vt[i].d, vt[i].w, vt[i].a, vt[i].m, vt[i].wdat, vt[i].e, vt[i].r);

      b2b(0, 32'h0001_0004, 32'hDEAD_BEEF);
      b2b(1, 32'h0001_0004, 32'hDEAD_BEAA);

      // reset lands on the edge that would commit the write
      @(negedge clk);
      addr = 32'h0001_0010; we = 1'b1; mask = 4'hF; wd = 32'h1234_5678;
      req[3] = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (ack[3]) seen = 1'b1;
      end
      rst = 1'b1;
      req[3] = 1'b0;
      @(negedge clk);
      if (ack[3]) seen = 1'b1;
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack[3]) seen = 1'b1;
      end
      chk("abort_no_ack", 32'(seen), 32'h0);
      txn(3, 1'b0, 32'h0001_0010, 4'h0, 32'h0, 1'b0, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
